// File: rtl/spmv_mem_arbiter_if.sv
// Bus bundle between the PE request FIFOs, the arbiter and the memory controller.
// The arbiter connects through the slave modport; the environment
// (request FIFOs plus memory controller) connects through the master modport.
interface spmv_mem_arbiter_if #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 64
);
  // Store requester
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ack;
  // Cache load requester
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_ack;
  // Decoder load requester
  logic              dec_valid;
  logic [ADDR_W-1:0] dec_addr;
  logic [1:0]        dec_tag;
  logic              dec_ack;
  // Memory request side
  logic              req_mem_ld;
  logic              req_mem_st;
  logic [ADDR_W-1:0] req_mem_addr;
  logic [DATA_W-1:0] req_mem_d_or_tag;
  logic              req_mem_stall;
  // Memory response side
  logic              rsp_mem_push;
  logic [2:0]        rsp_mem_tag;
  logic [DATA_W-1:0] rsp_mem_q;
  // Routed responses and status
  logic              cache_rsp_push;
  logic              dec_rsp_push;
  logic [1:0]        dec_rsp_tag;
  logic [DATA_W-1:0] rsp_q;
  logic [5:0]        outstanding;
  logic              idle;
  logic              rsp_underflow;

  modport slave (
    input  st_valid, st_addr, st_data,
    output st_ack,
    input  cache_valid, cache_addr,
    output cache_ack,
    input  dec_valid, dec_addr, dec_tag,
    output dec_ack,
    output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
    input  req_mem_stall,
    input  rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    output cache_rsp_push, dec_rsp_push, dec_rsp_tag, rsp_q,
    output outstanding, idle, rsp_underflow
  );

  modport master (
    output st_valid, st_addr, st_data,
    input  st_ack,
    output cache_valid, cache_addr,
    input  cache_ack,
    output dec_valid, dec_addr, dec_tag,
    input  dec_ack,
    input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
    output req_mem_stall,
    output rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    input  cache_rsp_push, dec_rsp_push, dec_rsp_tag, rsp_q,
    input  outstanding, idle, rsp_underflow
  );
endinterface

// File: rtl/spmv_mem_arbiter.sv
// Memory port arbiter for one SpMV PE: picks one of store / cache load /
// decoder load per cycle, issues it one cycle later, tracks load credits and
// steers tagged load responses back to the cache or the decoder.
module spmv_mem_arbiter #(
  parameter int ADDR_W          = 48,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 32,
  parameter int STARVE_LIMIT    = 8
) (
  input logic clk,
  input logic rst,
  spmv_mem_arbiter_if.slave bus
);

  localparam int         SW          = $clog2(STARVE_LIMIT + 1);
  localparam logic [5:0] MAX_OUT     = 6'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_ST, GNT_CACHE, GNT_DEC} grant_e;

  grant_e              grant;
  logic                ld_ok;
  logic                ld_ack;
  logic [SW-1:0]       starve_cnt;
  logic [5:0]          out_cnt;
  logic                underflow;
  logic                issue_st;
  logic                issue_ld;
  logic [ADDR_W-1:0]   issue_addr;
  logic [DATA_W-1:0]   issue_data;
  logic                cache_push;
  logic                dec_push;
  logic [1:0]          dec_tag_r;
  logic [DATA_W-1:0]   rsp_q_r;

  assign ld_ok  = out_cnt < MAX_OUT;
  assign ld_ack = (grant == GNT_CACHE) || (grant == GNT_DEC);

  // Pick this cycle's winner; a starved decoder overrides the fixed priority.
  always_comb begin
    grant = GNT_NONE;
    if (!rst && !bus.req_mem_stall) begin
      if (bus.dec_valid && ld_ok && starve_cnt == STARVE_MAX) grant = GNT_DEC;
      else if (bus.st_valid)                                  grant = GNT_ST;
      else if (bus.cache_valid && ld_ok)                      grant = GNT_CACHE;
      else if (bus.dec_valid && ld_ok)                        grant = GNT_DEC;
    end
  end

  assign bus.st_ack    = (grant == GNT_ST);
  assign bus.cache_ack = (grant == GNT_CACHE);
  assign bus.dec_ack   = (grant == GNT_DEC);

  // Count how often an eligible, waiting decoder loses; cleared when it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant == GNT_DEC) begin
      starve_cnt <= '0;
    end else if (bus.dec_valid && ld_ok && !bus.req_mem_stall &&
                 grant != GNT_NONE && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Register the granted request so it pulses on the memory port next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_st   <= 1'b0;
      issue_ld   <= 1'b0;
      issue_addr <= '0;
      issue_data <= '0;
    end else begin
      issue_st <= (grant == GNT_ST);
      issue_ld <= ld_ack;
      case (grant)
        GNT_ST: begin
          issue_addr <= bus.st_addr;
          issue_data <= bus.st_data;
        end
        GNT_CACHE: begin
          issue_addr <= bus.cache_addr;
          issue_data <= DATA_W'(3'b001);
        end
        GNT_DEC: begin
          issue_addr <= bus.dec_addr;
          issue_data <= DATA_W'({bus.dec_tag, 1'b0});
        end
        default: ;
      endcase
    end
  end

  // Load credits: +1 on a load grant, -1 on a response; a stray response is flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt   <= '0;
      underflow <= 1'b0;
    end else begin
      case ({ld_ack, bus.rsp_mem_push})
        2'b10: out_cnt <= out_cnt + 6'd1;
        2'b01: begin
          if (out_cnt == '0) underflow <= 1'b1;
          else               out_cnt   <= out_cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Route each load response by tag bit 0, one stage after it arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_push <= 1'b0;
      dec_push   <= 1'b0;
      dec_tag_r  <= '0;
      rsp_q_r    <= '0;
    end else begin
      cache_push <= bus.rsp_mem_push &&  bus.rsp_mem_tag[0];
      dec_push   <= bus.rsp_mem_push && !bus.rsp_mem_tag[0];
      if (bus.rsp_mem_push) rsp_q_r <= bus.rsp_mem_q;
      if (bus.rsp_mem_push && !bus.rsp_mem_tag[0]) dec_tag_r <= bus.rsp_mem_tag[2:1];
    end
  end

  assign bus.req_mem_st       = issue_st;
  assign bus.req_mem_ld       = issue_ld;
  assign bus.req_mem_addr     = issue_addr;
  assign bus.req_mem_d_or_tag = issue_data;
  assign bus.outstanding      = out_cnt;
  assign bus.rsp_underflow    = underflow;
  assign bus.cache_rsp_push   = cache_push;
  assign bus.dec_rsp_push     = dec_push;
  assign bus.dec_rsp_tag      = dec_tag_r;
  assign bus.rsp_q            = rsp_q_r;
  assign bus.idle = !bus.st_valid && !bus.cache_valid && !bus.dec_valid &&
                    out_cnt == '0 && !issue_ld && !issue_st;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Self-checking bench for spmv_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of grants, credits and response routing.
module tb_spmv_mem_arbiter;

  localparam int MAXO = 32;
  localparam int SL   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spmv_mem_arbiter_if #(.ADDR_W(48), .DATA_W(64)) bus ();

  spmv_mem_arbiter #(
    .ADDR_W(48), .DATA_W(64), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state (committed at the rising edge) and its next-state copy
  int          m_out,    n_out;
  int          m_starve, n_starve;
  logic        m_under,  n_under;
  logic        m_st,     n_st;
  logic        m_ld,     n_ld;
  logic [47:0] m_addr,   n_addr;
  logic [63:0] m_data,   n_data;
  logic        m_cp,     n_cp;
  logic        m_dp,     n_dp;
  logic [1:0]  m_dtag,   n_dtag;
  logic [63:0] m_q,      n_q;
  logic        e_st, e_ca, e_de, e_idle, lo;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic cv, input logic dv,
                               input logic [1:0] dt, input logic stall,
                               input logic push, input logic [2:0] tag);
    bus.st_valid      = sv;
    bus.st_addr       = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    bus.st_data       = {$urandom, $urandom};
    bus.cache_valid   = cv;
    bus.cache_addr    = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    bus.dec_valid     = dv;
    bus.dec_addr      = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    bus.dec_tag       = dt;
    bus.req_mem_stall = stall;
    bus.rsp_mem_push  = push;
    bus.rsp_mem_tag   = tag;
    bus.rsp_mem_q     = {$urandom, $urandom};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic modelReset();
    m_out = 0; m_starve = 0; m_under = 0; m_st = 0; m_ld = 0;
    m_addr = '0; m_data = '0; m_cp = 0; m_dp = 0; m_dtag = '0; m_q = '0;
    n_out = 0; n_starve = 0; n_under = 0; n_st = 0; n_ld = 0;
    n_addr = '0; n_data = '0; n_cp = 0; n_dp = 0; n_dtag = '0; n_q = '0;
  endtask

  // Model: derive this cycle's expected outputs, compare, and plan next state.
  always @(negedge clk) begin
    if (!rst) begin
      lo = (m_out < MAXO);
      e_st = 0; e_ca = 0; e_de = 0;
      if (!bus.req_mem_stall) begin
        if (bus.dec_valid && lo && m_starve == SL) e_de = 1;
        else if (bus.st_valid)                     e_st = 1;
        else if (bus.cache_valid && lo)            e_ca = 1;
        else if (bus.dec_valid && lo)              e_de = 1;
      end
      e_idle = !bus.st_valid && !bus.cache_valid && !bus.dec_valid &&
               m_out == 0 && !m_st && !m_ld;

      checkOutput("st_ack",         64'(bus.st_ack),         64'(e_st));
      checkOutput("cache_ack",      64'(bus.cache_ack),      64'(e_ca));
      checkOutput("dec_ack",        64'(bus.dec_ack),        64'(e_de));
      checkOutput("req_mem_st",     64'(bus.req_mem_st),     64'(m_st));
      checkOutput("req_mem_ld",     64'(bus.req_mem_ld),     64'(m_ld));
      checkOutput("req_mem_addr",   64'(bus.req_mem_addr),   64'(m_addr));
      checkOutput("req_d_or_tag",   bus.req_mem_d_or_tag,    m_data);
      checkOutput("outstanding",    64'(bus.outstanding),    64'(m_out));
      checkOutput("idle",           64'(bus.idle),           64'(e_idle));
      checkOutput("rsp_underflow",  64'(bus.rsp_underflow),  64'(m_under));
      checkOutput("cache_rsp_push", 64'(bus.cache_rsp_push), 64'(m_cp));
      checkOutput("dec_rsp_push",   64'(bus.dec_rsp_push),   64'(m_dp));
      checkOutput("dec_rsp_tag",    64'(bus.dec_rsp_tag),    64'(m_dtag));
      checkOutput("rsp_q",          bus.rsp_q,               m_q);

      n_st = e_st;
      n_ld = e_ca || e_de;
      n_addr = m_addr; n_data = m_data;
      if (e_st) begin n_addr = bus.st_addr;    n_data = bus.st_data; end
      if (e_ca) begin n_addr = bus.cache_addr; n_data = 64'd1; end
      if (e_de) begin n_addr = bus.dec_addr;   n_data = 64'(bus.dec_tag) * 2; end

      n_starve = m_starve;
      if (e_de) n_starve = 0;
      else if (bus.dec_valid && lo && !bus.req_mem_stall && (e_st || e_ca))
        n_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;

      n_out = m_out; n_under = m_under;
      if ((e_ca || e_de) && !bus.rsp_mem_push) n_out = m_out + 1;
      else if (!(e_ca || e_de) && bus.rsp_mem_push) begin
        if (m_out == 0) n_under = 1;
        else            n_out = m_out - 1;
      end

      n_cp = bus.rsp_mem_push && bus.rsp_mem_tag[0];
      n_dp = bus.rsp_mem_push && !bus.rsp_mem_tag[0];
      n_dtag = n_dp ? bus.rsp_mem_tag[2:1] : m_dtag;
      n_q = bus.rsp_mem_push ? bus.rsp_mem_q : m_q;
    end
  end

  // Commit the planned model state on the clock; clear it on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else begin
      m_out = n_out; m_starve = n_starve; m_under = n_under;
      m_st = n_st; m_ld = n_ld; m_addr = n_addr; m_data = n_data;
      m_cp = n_cp; m_dp = n_dp; m_dtag = n_dtag; m_q = n_q;
    end
  end

  initial begin
    int first_dec, n_st_acks, n_acks, n_pulses;
    logic sv, cv, dv, st, pu;

    // Reset during traffic
    doReset();
    applyStimulus(1, 0, 0, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("rst_pre_st_ack", 64'(bus.st_ack), 64'd1);
    cyc();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_req_st", 64'(bus.req_mem_st), 64'd0);
    checkOutput("rst_st_ack", 64'(bus.st_ack), 64'd0);
    checkOutput("rst_outstanding", 64'(bus.outstanding), 64'd0);
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_idle", 64'(bus.idle), 64'd1);

    // Priority store > cache > decoder, and load tag encoding
    doReset();
    applyStimulus(1, 1, 1, 2'd2, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("prio_st", 64'(bus.st_ack), 64'd1);
    cyc();
    applyStimulus(0, 1, 1, 2'd2, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("prio_cache", 64'(bus.cache_ack), 64'd1);
    checkOutput("prio_issue_st", 64'(bus.req_mem_st), 64'd1);
    cyc();
    applyStimulus(0, 0, 1, 2'd2, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("prio_dec", 64'(bus.dec_ack), 64'd1);
    checkOutput("cache_tag", bus.req_mem_d_or_tag, 64'd1);
    cyc();
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("dec_tag_enc", bus.req_mem_d_or_tag, 64'd4);
    checkOutput("dec_issue_ld", 64'(bus.req_mem_ld), 64'd1);
    cyc();

    // Starvation override
    doReset();
    applyStimulus(1, 0, 1, 2'd1, 0, 0, 3'd0);
    first_dec = 0; n_st_acks = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.dec_ack && first_dec == 0) first_dec = i;
      if (bus.st_ack && first_dec == 0) n_st_acks++;
      if (i == 10) checkOutput("starve_resume", 64'(bus.st_ack), 64'd1);
      cyc();
    end
    checkOutput("starve_st_count", 64'(n_st_acks), 64'd8);
    checkOutput("starve_dec_cycle", 64'(first_dec), 64'd9);

    // Credit limit
    doReset();
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 3'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cyc();
    end
    @(negedge clk);
    checkOutput("credit_full", 64'(bus.outstanding), 64'd32);
    checkOutput("credit_block", 64'(bus.cache_ack), 64'd0);
    cyc();
    applyStimulus(1, 1, 0, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("credit_st_ok", 64'(bus.st_ack), 64'd1);
    cyc();
    applyStimulus(0, 1, 0, 2'd0, 0, 1, 3'd1);
    @(negedge clk);
    checkOutput("credit_still_full", 64'(bus.cache_ack), 64'd0);
    cyc();
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("credit_31", 64'(bus.outstanding), 64'd31);
    checkOutput("credit_rsp_push", 64'(bus.cache_rsp_push), 64'd1);
    checkOutput("credit_reaccept", 64'(bus.cache_ack), 64'd1);
    cyc();

    // Stall
    doReset();
    applyStimulus(1, 1, 1, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("stall_pre", 64'(bus.st_ack), 64'd1);
    cyc();
    n_acks = 0; n_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 1, 2'd0, 1, 0, 3'd0);
      @(negedge clk);
      n_acks   += int'(bus.st_ack) + int'(bus.cache_ack) + int'(bus.dec_ack);
      n_pulses += int'(bus.req_mem_st) + int'(bus.req_mem_ld);
      cyc();
    end
    checkOutput("stall_acks", 64'(n_acks), 64'd0);
    checkOutput("stall_pulses", 64'(n_pulses), 64'd1);
    applyStimulus(1, 1, 1, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("stall_resume", 64'(bus.st_ack), 64'd1);
    cyc();

    // Underflow and decoder routing
    doReset();
    applyStimulus(0, 0, 0, 2'd0, 0, 1, 3'b110);
    cyc();
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    @(negedge clk);
    checkOutput("uf_dec_push", 64'(bus.dec_rsp_push), 64'd1);
    checkOutput("uf_dec_tag", 64'(bus.dec_rsp_tag), 64'd3);
    checkOutput("uf_flag", 64'(bus.rsp_underflow), 64'd1);
    checkOutput("uf_outstanding", 64'(bus.outstanding), 64'd0);
    cyc();
    @(negedge clk);
    checkOutput("uf_push_pulse", 64'(bus.dec_rsp_push), 64'd0);
    checkOutput("uf_sticky", 64'(bus.rsp_underflow), 64'd1);
    cyc();

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      sv = ($urandom % 4) == 0;
      cv = ($urandom % 2) == 0;
      dv = ($urandom % 2) == 0;
      st = ($urandom % 5) == 0;
      pu = (m_out > 0) ? (($urandom % 3) == 0) : (($urandom % 50) == 0);
      applyStimulus(sv, cv, dv, 2'($urandom), st, pu, 3'($urandom));
      cyc();
    end
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 3'd0);
    cyc();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
- Shares the PE's single memory request port among three requesters:
  - the MAC result store path;
  - the x-vector cache load path;
  - the matrix decoder load path.
- Encodes load tags, tracks outstanding load credits and routes load responses back to the cache or the decoder by tag.
- Sits between the PE's per-requester request FIFOs and the memory controller interface.

Parameters:
ADDR_W, 48, memory address width
DATA_W, 64, store data / response data width
MAX_OUTSTANDING, 32, maximum loads in flight (must be >= 2)
STARVE_LIMIT, 8, consecutive lost arbitrations before the decoder is forced to win

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
st_valid  in  1  store request pending (held until st_ack)
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
st_ack  out  1  store accepted this cycle (combinational)
cache_valid  in  1  cache load pending
cache_addr  in  ADDR_W  cache load address
cache_ack  out  1  cache load accepted (combinational)
dec_valid  in  1  decoder load pending
dec_addr  in  ADDR_W  decoder load address
dec_tag  in  2  decoder stream id
dec_ack  out  1  decoder load accepted (combinational)
req_mem_ld  out  1  load request pulse
req_mem_st  out  1  store request pulse
req_mem_addr  out  ADDR_W  request address
req_mem_d_or_tag  out  DATA_W  store data or load tag
req_mem_stall  in  1  memory back-pressure
rsp_mem_push  in  1  load response valid
rsp_mem_tag  in  3  response tag
rsp_mem_q  in  DATA_W  response data
cache_rsp_push  out  1  response for cache
dec_rsp_push  out  1  response for decoder
dec_rsp_tag  out  2  decoder stream id of response
rsp_q  out  DATA_W  registered response data
outstanding  out  6  loads in flight
idle  out  1  no pending, issued or outstanding traffic
rsp_underflow  out  1  sticky: response arrived with outstanding == 0

Behaviour:
- Reset (async, rst=1): all outputs 0, outstanding 0, starvation counter 0, sticky flag cleared. rst takes effect mid-operation with no drain; in-flight responses after reset are counted as underflow.
- Grant cycle:
  - At most one ack per cycle; no ack while req_mem_stall=1.
  - Load requesters are eligible only if outstanding < MAX_OUTSTANDING. The store requester is always eligible.
  - Priority order: store > cache > decoder.
  - Override: if the starvation counter == STARVE_LIMIT and decoder is eligible, decoder wins over both.
- Starvation counter:
  - Increments (saturating) on each cycle where dec_valid=1, decoder is eligible, stall=0 and another requester is acked.
  - Clears on dec_ack.
  - Unchanged otherwise.
- Issue:
  - One-cycle latency: the cycle after an ack, exactly one of req_mem_st/req_mem_ld pulses high for one cycle with the registered address.
  - Store: req_mem_d_or_tag = st_data.
  - Cache load: req_mem_d_or_tag = zero-extended {2'b00, 1'b1}.
  - Decoder load: req_mem_d_or_tag = zero-extended {dec_tag, 1'b0}.
  - When not issuing: req_mem_ld and req_mem_st are 0; address/data hold their last value.
  - Stall sampled at the grant cycle only; an already-registered request issues regardless of stall.
- Credits:
  - outstanding increments in the cycle a load ack occurs and decrements on rsp_mem_push. Both in the same cycle: unchanged.
  - Decrement with outstanding == 0: stays 0, rsp_underflow set.
- Response routing, registered one stage, latency 1:
  - rsp_q <= rsp_mem_q on every push.
  - If rsp_mem_tag[0]=1: cache_rsp_push=1.
  - Else: dec_rsp_push=1 and dec_rsp_tag = rsp_mem_tag[2:1].
  - Push outputs are single-cycle pulses.
- idle = !st_valid && !cache_valid && !dec_valid && outstanding==0 && !req_mem_ld && !req_mem_st (registered-output terms).

Test Plan:
- Reset during traffic: st_valid=1, assert rst mid-cycle -> all outputs 0 immediately; outstanding=0; idle=1 after valids drop.
- Priority: all three valid, stall=0 for 3 cycles, STARVE_LIMIT=8:
  - acks in order st, cache, dec;
  - req_mem_d_or_tag for the cache load = 1;
  - req_mem_d_or_tag for the decoder load with dec_tag=2 = 4.
- Starvation: st_valid and dec_valid held high, stall=0 -> 8 st_acks, then dec_ack on cycle 9; store resumes cycle 10.
- Credits: issue 32 cache loads with no responses -> outstanding=32, cache_ack stays 0 while st_ack still granted. One response with tag=1 -> outstanding=31, cache_rsp_push one cycle later, next cache load accepted.
- Stall: req_mem_stall=1 for 5 cycles with all valid -> no acks and no new req pulses beyond the one already registered; grant resumes the first cycle stall=0.
- Underflow/routing: rsp_mem_push with tag=3'b110 at outstanding=0 -> dec_rsp_push=1, dec_rsp_tag=3, rsp_underflow=1 sticky, outstanding=0.
